// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared types and constants for the control sequencer
package cpu_ctrl_pkg;

    // Sequencer states; T0..T5 are the fetch/execute control steps.
    typedef enum logic [2:0] {
        IDLE,
        T0,
        T1,
        T2,
        T3,
        T4,
        T5,
        HALT
    } state_t;

    // Opcodes live in ir[31:27].
    localparam logic [4:0] OP_LDI  = 5'b01000;
    localparam logic [4:0] OP_ADDI = 5'b01001;
    localparam logic [4:0] OP_ANDI = 5'b01010;
    localparam logic [4:0] OP_ORI  = 5'b01011;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // One-hot ALU operation codes at the native 12-bit ALU width.
    localparam logic [11:0] ALU_ADD = 12'h001;
    localparam logic [11:0] ALU_AND = 12'h100;
    localparam logic [11:0] ALU_OR  = 12'h200;

endpackage

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - datapath control bundle between sequencer and datapath
// master: the sequencer (samples run/ir, drives every control strobe and status)
// slave : the datapath side (drives run/ir, observes controls and status)
interface control_sequencer_if #(
    parameter int ALU_W = 12,
    parameter int CNT_W = 16
);
    logic             run;
    logic [31:0]      ir;
    logic             PCout, MARin, IncPC, Zin, PCin, Zlowout;
    logic             MDRRead, MDRin, MDRout, IRin;
    logic             Gra, Grb, Grc, Rin_in, Rout_in, BAout, Yin, Cout;
    logic [ALU_W-1:0] ALUControl;
    logic             busy, done, illegal;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  run, ir,
        output PCout, MARin, IncPC, Zin, PCin, Zlowout,
        output MDRRead, MDRin, MDRout, IRin,
        output Gra, Grb, Grc, Rin_in, Rout_in, BAout, Yin, Cout,
        output ALUControl, busy, done, illegal, instr_count
    );

    modport slave (
        output run, ir,
        input  PCout, MARin, IncPC, Zin, PCin, Zlowout,
        input  MDRRead, MDRin, MDRout, IRin,
        input  Gra, Grb, Grc, Rin_in, Rout_in, BAout, Yin, Cout,
        input  ALUControl, busy, done, illegal, instr_count
    );
endinterface

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode classifier for the control sequencer
// op_i         : 5-bit opcode
// valid_o      : opcode is one of ldi/addi/andi/ori
// is_halt_o    : opcode is halt
// uses_baout_o : operand B comes from BAout (ldi) rather than Rout_in
// alu_code_o   : one-hot ALU operation for the execute step
module ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int ALU_W = 12
) (
    input  logic [4:0]       op_i,
    output logic             valid_o,
    output logic             is_halt_o,
    output logic             uses_baout_o,
    output logic [ALU_W-1:0] alu_code_o
);

    always_comb begin
        valid_o      = 1'b0;
        is_halt_o    = 1'b0;
        uses_baout_o = 1'b0;
        alu_code_o   = '0;
        case (op_i)
            OP_LDI: begin
                valid_o      = 1'b1;
                uses_baout_o = 1'b1;
                alu_code_o   = ALU_W'(ALU_ADD);
            end
            OP_ADDI: begin
                valid_o    = 1'b1;
                alu_code_o = ALU_W'(ALU_ADD);
            end
            OP_ANDI: begin
                valid_o    = 1'b1;
                alu_code_o = ALU_W'(ALU_AND);
            end
            OP_ORI: begin
                valid_o    = 1'b1;
                alu_code_o = ALU_W'(ALU_OR);
            end
            OP_HALT: is_halt_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/execute sequencer, one control step per clock
// clk : rising-edge clock
// clr : synchronous active-low reset
// bus : master side of control_sequencer_if (run/ir in; control strobes,
//       ALUControl, busy, done, illegal, instr_count out)
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 0,
    parameter int ALU_W    = 12,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 clr,
    control_sequencer_if.master  bus
);

    state_t           state_q, state_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic [4:0]       op_q, op_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             dec_valid, dec_halt, dec_baout;
    logic [ALU_W-1:0] dec_alu;
    logic [4:0]       dec_op;
    logic             unused_ir;

    assign unused_ir = ^bus.ir[26:0];

    // A single decoder serves both steps: in T3 it classifies the live
    // opcode, afterwards it re-derives the ALU code from the latched op.
    assign dec_op = (state_q == T3) ? bus.ir[31:27] : op_q;

    ctrl_decode #(.ALU_W(ALU_W)) u_decode (
        .op_i         (dec_op),
        .valid_o      (dec_valid),
        .is_halt_o    (dec_halt),
        .uses_baout_o (dec_baout),
        .alu_code_o   (dec_alu)
    );

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            op_q      <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: if (bus.run) state_d = T0;
            T0: begin
                state_d = T1;
                wcnt_d  = '0;
            end
            T1: begin
                if (wcnt_q == 4'(MEM_WAIT)) state_d = T2;
                else                        wcnt_d  = wcnt_q + 4'd1;
            end
            T2: state_d = T3;
            T3: begin
                op_d = bus.ir[31:27];
                if (dec_valid) begin
                    state_d = T4;
                end else begin
                    // halt and unknown opcodes both park; only unknown traps.
                    state_d = HALT;
                    if (!dec_halt) illegal_d = 1'b1;
                end
            end
            T4: state_d = T5;
            T5: begin
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                state_d = bus.run ? T0 : IDLE;
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.PCout      = 1'b0;
        bus.MARin      = 1'b0;
        bus.IncPC      = 1'b0;
        bus.Zin        = 1'b0;
        bus.PCin       = 1'b0;
        bus.Zlowout    = 1'b0;
        bus.MDRRead    = 1'b0;
        bus.MDRin      = 1'b0;
        bus.MDRout     = 1'b0;
        bus.IRin       = 1'b0;
        bus.Gra        = 1'b0;
        bus.Grb        = 1'b0;
        bus.Grc        = 1'b0;
        bus.Rin_in     = 1'b0;
        bus.Rout_in    = 1'b0;
        bus.BAout      = 1'b0;
        bus.Yin        = 1'b0;
        bus.Cout       = 1'b0;
        bus.ALUControl = '0;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        case (state_q)
            T0: begin
                bus.busy  = 1'b1;
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
            end
            T1: begin
                bus.busy    = 1'b1;
                bus.MDRRead = 1'b1;
                bus.MDRin   = 1'b1;
                // The incremented PC is written back only once per fetch.
                if (wcnt_q == 4'd0) begin
                    bus.PCin    = 1'b1;
                    bus.Zlowout = 1'b1;
                end
            end
            T2: begin
                bus.busy   = 1'b1;
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            T3: begin
                bus.busy = 1'b1;
                if (dec_valid) begin
                    bus.Grb     = 1'b1;
                    bus.Yin     = 1'b1;
                    bus.BAout   = dec_baout;
                    bus.Rout_in = !dec_baout;
                end
            end
            T4: begin
                bus.busy       = 1'b1;
                bus.Cout       = 1'b1;
                bus.Zin        = 1'b1;
                bus.ALUControl = dec_alu;
            end
            T5: begin
                bus.busy    = 1'b1;
                bus.Zlowout = 1'b1;
                bus.Gra     = 1'b1;
                bus.Rin_in  = 1'b1;
                bus.done    = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.illegal     = illegal_q;
    assign bus.instr_count = cnt_q;

endmodule
